// File: rtl/debug_pkg.sv
// Shared definitions for the debug trace gate: word width, default key and
// the access-control state encoding.
package debug_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] DEFAULT_UNLOCK_KEY = 32'hA5C3_0F1E;

    // Fixed encoding so the state can be probed from legacy debug tooling.
    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } gate_state_t;

endpackage

// File: rtl/debug_trace_fifo.sv
// Show-ahead synchronous FIFO with flush; push while full is accepted only
// when a pop frees the head slot in the same cycle.
module debug_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; count=0 already hides stale entries, and
    // leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/debug_trace_gate.sv
// Key-protected capture buffer for the upstream debug word, with lockout after
// repeated bad keys and a flush on every relock.
module debug_trace_gate
    import debug_pkg::*;
#(
    parameter int                DEPTH          = 8,
    parameter logic [DATA_W-1:0] UNLOCK_KEY     = DEFAULT_UNLOCK_KEY,
    parameter int                MAX_FAIL       = 3,
    parameter int                LOCKOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic [DATA_W-1:0]      cap_data,
    input  logic                   unlock_valid,
    input  logic [DATA_W-1:0]      unlock_key,
    input  logic                   lock,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   unlocked,
    output logic                   locked_out,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    gate_state_t       state, state_nxt;
    logic [FAIL_W-1:0] fail_cnt, fail_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              relock;

    assign unlocked   = (state == UNLOCKED);
    assign locked_out = (state == LOCKOUT);
    assign rd_valid   = unlocked & ~fifo_empty;
    assign rd_data    = rd_valid ? fifo_head : '0;
    assign pop        = rd_valid & rd_ready;
    assign relock     = unlocked & lock;
    assign push_req   = unlocked & cap_en;
    assign push_ok    = push_req & (~fifo_full | pop);

    // NOTE: every target gets a default first so no path leaves a latch.
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        timer_nxt = timer;
        case (state)
            LOCKED: begin
                // A simultaneous relock request swallows the key attempt.
                if (unlock_valid && !lock) begin
                    if (unlock_key == UNLOCK_KEY) begin
                        state_nxt = UNLOCKED;
                        fail_nxt  = '0;
                    end else if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
                        state_nxt = LOCKOUT;
                        fail_nxt  = FAIL_W'(MAX_FAIL);
                        timer_nxt = TMR_W'(LOCKOUT_CYCLES);
                    end else begin
                        fail_nxt = fail_cnt + 1'b1;
                    end
                end
            end
            UNLOCKED: begin
                if (lock) state_nxt = LOCKED;
            end
            LOCKOUT: begin
                if (timer == TMR_W'(1)) begin
                    state_nxt = LOCKED;
                    fail_nxt  = '0;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = LOCKED;
        endcase
    end

    // NOTE: registers use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOCKED;
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
            timer    <= timer_nxt;
        end
    end

    // Relock takes priority so a drop in the same cycle cannot re-arm the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (relock) begin
            overflow <= 1'b0;
        end else if (push_req && !push_ok) begin
            overflow <= 1'b1;
        end
    end

    debug_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_ok),
        .pop     (pop),
        .flush   (relock),
        .wr_data (cap_data),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_debug_trace_gate.sv
// Directed bench for debug_trace_gate; reads are checked against a queue of
// words the bench expects the gate to have accepted.
module tb_debug_trace_gate;

    localparam logic [31:0] GOOD_KEY = 32'hA5C3_0F1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        cap_en;
    logic [31:0] cap_data;
    logic        unlock_valid;
    logic [31:0] unlock_key;
    logic        lock;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        unlocked;
    logic        locked_out;
    logic [3:0]  fifo_count;
    logic        overflow;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    debug_trace_gate dut (
        .clk          (clk),
        .rst          (rst),
        .cap_en       (cap_en),
        .cap_data     (cap_data),
        .unlock_valid (unlock_valid),
        .unlock_key   (unlock_key),
        .lock         (lock),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .unlocked     (unlocked),
        .locked_out   (locked_out),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Score any pop about to happen, then advance to just after the next edge.
    task automatic cycle();
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_read", 32'(exp_q.size()), 32'd1);
            else check("sb_rd_data", rd_data, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cap_en       = 1'b0;
        cap_data     = '0;
        unlock_valid = 1'b0;
        unlock_key   = '0;
        lock         = 1'b0;
        rd_ready     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_unlocked"},   32'(unlocked),   32'd0);
        check({tag, "_locked_out"}, 32'(locked_out), 32'd0);
        check({tag, "_count"},      32'(fifo_count), 32'd0);
        check({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
        check({tag, "_rd_data"},    rd_data,         32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
    endtask

    task automatic present_key(input logic [31:0] key);
        unlock_valid = 1'b1;
        unlock_key   = key;
        cycle();
        unlock_valid = 1'b0;
        unlock_key   = '0;
    endtask

    initial begin
        int lo_cycles;
        logic saw_unlock;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        cycle();

        // Capture while locked is ignored.
        for (int i = 1; i <= 4; i++) begin
            cap_en   = 1'b1;
            cap_data = 32'h1111_0000 + 32'(i);
            cycle();
        end
        cap_en = 1'b0;
        check_reset_outputs("locked_cap");

        // Unlock; a sample in the key cycle must not be captured.
        cap_en   = 1'b1;
        cap_data = 32'hBAD0_0000;
        present_key(GOOD_KEY);
        check("unlock_latency", 32'(unlocked), 32'd1);
        check("unlock_cycle_cap", 32'(fifo_count), 32'd0);

        rd_ready = 1'b1;
        cap_data = 32'hDEAD_BEEF;
        exp_q.push_back(cap_data);
        cycle();
        check("wr_to_rd_valid", 32'(rd_valid), 32'd1);
        cap_data = 32'h0000_0042;
        exp_q.push_back(cap_data);
        cycle();
        check("push_pop_count", 32'(fifo_count), 32'd1);
        cap_en = 1'b0;
        cycle();
        check("drained_count", 32'(fifo_count), 32'd0);

        // Fill to DEPTH, then one more write that must be dropped.
        rd_ready = 1'b0;
        cap_en   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cap_data = 32'h2000_0000 + 32'(i);
            if (i < 8) exp_q.push_back(cap_data);
            cycle();
        end
        check("full_count", 32'(fifo_count), 32'd8);
        check("overflow_set", 32'(overflow), 32'd1);

        // Write while full with a pop in the same cycle is accepted.
        rd_ready = 1'b1;
        cap_data = 32'h3000_0009;
        exp_q.push_back(cap_data);
        cycle();
        check("full_push_pop_count", 32'(fifo_count), 32'd8);
        cap_en = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("full_drained", 32'(fifo_count), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Relock with writes and a pop in the same cycle: all discarded.
        rd_ready = 1'b0;
        cap_en   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cap_data = 32'h4000_0000 + 32'(i);
            exp_q.push_back(cap_data);
            cycle();
        end
        check("relock_pre_count", 32'(fifo_count), 32'd5);
        cap_data = 32'h4000_0099;
        rd_ready = 1'b1;
        lock     = 1'b1;
        cycle();
        exp_q.delete();
        lock     = 1'b0;
        cap_en   = 1'b0;
        rd_ready = 1'b0;
        check("relock_unlocked", 32'(unlocked), 32'd0);
        check("relock_count", 32'(fifo_count), 32'd0);
        check("relock_rd_valid", 32'(rd_valid), 32'd0);
        check("relock_rd_data", rd_data, 32'd0);
        check("relock_overflow", 32'(overflow), 32'd0);
        present_key(GOOD_KEY);
        check("reunlock", 32'(unlocked), 32'd1);
        check("reunlock_count", 32'(fifo_count), 32'd0);
        check("reunlock_rd_valid", 32'(rd_valid), 32'd0);

        // Back to LOCKED; lock alongside a key wins and the attempt is not counted.
        lock = 1'b1;
        cycle();
        unlock_valid = 1'b1;
        unlock_key   = GOOD_KEY;
        cycle();
        check("lock_beats_key", 32'(unlocked), 32'd0);
        unlock_key = 32'h0;
        cycle();
        lock = 1'b0;
        present_key(32'h0);
        present_key(32'h0);
        check("two_bad_keys", 32'(locked_out), 32'd0);
        present_key(32'h0);
        check("lockout_entry", 32'(locked_out), 32'd1);

        // Count lockout cycles while hammering the correct key.
        lo_cycles  = 1;
        saw_unlock = 1'b0;
        while (locked_out === 1'b1 && lo_cycles < 400) begin
            unlock_valid = 1'b1;
            unlock_key   = GOOD_KEY;
            cycle();
            if (unlocked === 1'b1) saw_unlock = 1'b1;
            if (locked_out === 1'b1) lo_cycles++;
        end
        unlock_valid = 1'b0;
        check("lockout_length", 32'(lo_cycles), 32'd256);
        check("lockout_key_ignored", 32'(saw_unlock), 32'd0);
        check("post_lockout_locked", 32'(unlocked), 32'd0);
        present_key(GOOD_KEY);
        check("post_lockout_unlock", 32'(unlocked), 32'd1);

        // Asynchronous reset mid-operation.
        cap_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cap_data = 32'h5000_0000 + 32'(i);
            exp_q.push_back(cap_data);
            cycle();
        end
        cap_en = 1'b0;
        check("pre_reset_count", 32'(fifo_count), 32'd3);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        check("post_rst_locked", 32'(unlocked), 32'd0);
        present_key(GOOD_KEY);
        check("post_rst_unlock", 32'(unlocked), 32'd1);
        check("post_rst_empty", 32'(fifo_count), 32'd0);
        check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
